trace_invariant_checker: RTL

- Sequential monitor on the receiving end of the arithmetic-case stimulus path: the bench drives `selector` into `top`, and this block consumes `top`'s `i` and `sn` trace.
- Evaluates three candidate invariants every accepted sample: `sn == i`, `sn <= i`, and `sn` non-decreasing.
- Keeps sticky pass flags, a violation counter and first-failure cycle, and buffers violating samples in a small FIFO drained by a valid/ready reader.
- Stops after a fixed sample budget, matching the 1000-cycle bench run.

---
 rtl/viol_if.sv | 21 ++
 rtl/trace_invariant_checker.sv | 127 ++++++++++++
 2 files changed

// File: rtl/viol_if.sv
// Violation FIFO read port: valid/ready handshake with the entry payload.
// master = checker (drives valid/data), slave = reader (drives ready).
interface viol_if #(
  parameter int DW = 36
);
  logic          viol_valid;
  logic          viol_ready;
  logic [DW-1:0] viol_data;

  modport master (
    output viol_valid,
    output viol_data,
    input  viol_ready
  );

  modport slave (
    input  viol_valid,
    input  viol_data,
    output viol_ready
  );
endinterface

// File: rtl/trace_invariant_checker.sv
// Monitors the i/sn trace for eq, le and monotonic-sn invariants; keeps
// sticky pass flags, a saturating fail count, the first failing sample
// index and a small FIFO of violating samples drained over viol_if.
// Ports: clk, rst (sync, active-high), sample_valid/selector/i/sn in,
// eq/le/mono_holds, fail_count, first_fail_valid/cycle, overflow, done out,
// viol (master): viol_valid, viol_ready, viol_data
//   viol_data = {cycle, selector, eq_f, le_f, mono_f, i, sn}.
module trace_invariant_checker #(
  parameter int WIDTH       = 8,
  parameter int MAX_SAMPLES = 1000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic             selector,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] sn,
  output logic             eq_holds,
  output logic             le_holds,
  output logic             mono_holds,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_cycle,
  output logic             overflow,
  output logic             done,
  viol_if.master           viol
);

  localparam int DW = 2*WIDTH + CNT_W + 4;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] prev_sn;

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;

  logic accept;
  logic eq_f;
  logic le_f;
  logic mono_f;
  logic viol_s;
  logic last;
  logic full;
  logic pop;
  logic push;
  logic [DW-1:0] entry;

  assign accept = sample_valid && (state != DONE);
  assign eq_f   = (sn != i);
  assign le_f   = (sn > i);
  // The first sample has no predecessor, so mono only applies in RUN.
  assign mono_f = (state == RUN) && (sn < prev_sn);
  assign viol_s = accept && (eq_f || le_f || mono_f);
  assign last   = (idx == CNT_W'(MAX_SAMPLES - 1));

  assign full = (occ == OW'(FIFO_DEPTH));
  assign pop  = viol.viol_valid && viol.viol_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push = viol_s && (!full || pop);

  assign entry = {idx, selector, eq_f, le_f, mono_f, i, sn};

  assign viol.viol_valid = (occ != '0);
  assign viol.viol_data  = mem[rd_ptr];
  assign done            = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      prev_sn          <= '0;
      eq_holds         <= 1'b1;
      le_holds         <= 1'b1;
      mono_holds       <= 1'b1;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_cycle <= '0;
      overflow         <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
    end else begin
      if (accept) begin
        prev_sn <= sn;
        idx     <= idx + 1'b1;
        unique case (1'b1)
          last:           state <= DONE;
          (state == IDLE): state <= RUN;
          default:        state <= state;
        endcase
        if (eq_f)   eq_holds   <= 1'b0;
        if (le_f)   le_holds   <= 1'b0;
        if (mono_f) mono_holds <= 1'b0;
      end
      if (viol_s) begin
        if (fail_count != '1)
          fail_count <= fail_count + 1'b1;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_cycle <= idx;
        end
        if (full && !pop)
          overflow <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= entry;
  end

endmodule
